flash_read_responder: RTL

Avalon-MM pipelined read responder: the slave-side counterpart of the flash-reading path in the music player. It accepts word reads on the `flsh_*` bus and returns 32-bit words from an internal preloadable sample memory. Wait states, read latency and the outstanding-read limit are programmable. It stands in for the flash controller in simulation and in on-chip-sample builds, so the existing reader FSM can be exercised against exact, repeatable bus timing.

---
 rtl/flash_rd_if.sv | 28 ++
 rtl/flash_read_responder.sv | 96 +++++++++
 2 files changed

// File: rtl/flash_rd_if.sv
// Avalon-MM pipelined read bus between the flash reader and its responder.
// The master drives commands; the slave returns stalls and read data.
interface flash_rd_if;
  logic [22:0] flsh_address;
  logic        flsh_read;
  logic [3:0]  flsh_byteenable;
  logic        flsh_waitrequest;
  logic [31:0] flsh_readdata;
  logic        flsh_readdatavalid;

  modport master (
    output flsh_address,
    output flsh_read,
    output flsh_byteenable,
    input  flsh_waitrequest,
    input  flsh_readdata,
    input  flsh_readdatavalid
  );

  modport slave (
    input  flsh_address,
    input  flsh_read,
    input  flsh_byteenable,
    output flsh_waitrequest,
    output flsh_readdata,
    output flsh_readdatavalid
  );
endinterface

// File: rtl/flash_read_responder.sv
// Avalon-MM read responder backed by a preloadable sample memory.
// FLASH_RESP_BYTE_MASK_EN: zero byte lanes whose byteenable is low.
module flash_read_responder #(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2,
  parameter int LATENCY     = 3,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  flash_rd_if.slave             bus,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [3:0]            wcnt;
  logic [3:0]            pend;
  logic [LATENCY-1:0]    pv;
  logic [31:0]           pd [LATENCY];
  logic [DEPTH_LOG2-1:0] ra;
  logic [31:0]           rword;
  logic                  wait_hi;
  logic                  full;
  logic                  acc;
  logic                  unused_hi;

  assign ra        = bus.flsh_address[DEPTH_LOG2-1:0];
  assign unused_hi = ^bus.flsh_address;

  if (WAIT_CYCLES > 0) begin : g_wait
    assign wait_hi = wcnt < 4'(WAIT_CYCLES);
  end else begin : g_nowait
    assign wait_hi = 1'b0;
  end

  assign full = pend == 4'(MAX_PENDING);
  assign bus.flsh_waitrequest = rst | full | wait_hi;
  assign acc = bus.flsh_read & ~bus.flsh_waitrequest;

`ifdef FLASH_RESP_BYTE_MASK_EN
  logic [31:0] bmask;
  assign bmask = {{8{bus.flsh_byteenable[3]}},
                  {8{bus.flsh_byteenable[2]}},
                  {8{bus.flsh_byteenable[1]}},
                  {8{bus.flsh_byteenable[0]}}};
  assign rword = mem[ra] & bmask;
`else
  logic unused_be;
  assign unused_be = ^bus.flsh_byteenable;
  assign rword     = mem[ra];
`endif

  // Array read happens before this write lands, so a same-cycle
  // collision returns the old word.
  always_ff @(posedge clk) begin
    if (ld_we)
      mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      pend <= '0;
      pv   <= '0;
    end else begin
      if (acc || !bus.flsh_read)
        wcnt <= '0;
      else if (wait_hi)
        wcnt <= wcnt + 4'd1;
      pend <= pend + {3'b0, acc} - {3'b0, pv[LATENCY-1]};
      pv[0] <= acc;
      for (int i = 1; i < LATENCY; i++)
        pv[i] <= pv[i-1];
    end
  end

  // Stages only load behind a valid bit, so the last one holds its word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++)
        pd[i] <= '0;
    end else begin
      if (acc)
        pd[0] <= rword;
      for (int i = 1; i < LATENCY; i++)
        if (pv[i-1])
          pd[i] <= pd[i-1];
    end
  end

  assign bus.flsh_readdata      = pd[LATENCY-1];
  assign bus.flsh_readdatavalid = pv[LATENCY-1];
endmodule
